// File: rtl/seq101_gen_if.sv
// Request/serial-output bundle for seq101_gen: the master issues start/pattern/len/rep,
// and the slave (the generator) returns x/valid/busy/done.
interface seq101_gen_if #(
  parameter int W  = 8,
  parameter int LW = 4,
  parameter int RW = 4
);
  logic          start;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
  logic [RW-1:0] rep;
  logic          x;
  logic          valid;
  logic          busy;
  logic          done;

  modport master (
    output start, pattern, len, rep,
    input  x, valid, busy, done
  );

  modport slave (
    input  start, pattern, len, rep,
    output x, valid, busy, done
  );
endinterface

// File: rtl/seq101_gen.sv
// Serial pattern generator: shifts pattern MSB-first, (rep+1) times, with every output registered.
// Define SEQ_GEN_GAP_EN to insert GAP idle-zero cycles between repetitions.
module seq101_gen #(
  parameter int          W   = 8,
  parameter int          LW  = 4,
  parameter int          RW  = 4,
  parameter int unsigned GAP = 2
) (
  input  logic        clk,
  input  logic        clr,
  seq101_gen_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [LW-1:0] W_L = LW'(W);

`ifdef SEQ_GEN_GAP_EN
  localparam bit GAP_ON = (GAP > 0);
  localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
`else
  // The contiguous build never gaps; GAP is still referenced so both builds share one parameter list.
  localparam bit GAP_ON = 1'b0 && (GAP > 0);
`endif

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [LW-1:0] idx_q, idx_d;
`ifdef SEQ_GEN_GAP_EN
  logic [GW-1:0] gap_q, gap_d;
`endif
  logic          x_q, x_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic len_ok;
  assign len_ok = (bus.len != '0) && (bus.len <= W_L);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
`ifdef SEQ_GEN_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      S_IDLE: begin
        // busy_q still shows the DONE cycle one clock late, so start is held off through it.
        if (bus.start && !busy_q && len_ok) begin
          pat_d   = bus.pattern;
          len_d   = bus.len;
          rep_d   = bus.rep;
          idx_d   = bus.len - LW'(1);
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (idx_q == '0) begin
          if (rep_q != '0) begin
            rep_d   = rep_q - RW'(1);
            idx_d   = len_q - LW'(1);
            state_d = GAP_ON ? S_GAP : S_SEND;
`ifdef SEQ_GEN_GAP_EN
            gap_d   = '0;
`endif
          end else begin
            state_d = S_DONE;
          end
        end else begin
          idx_d = idx_q - LW'(1);
        end
      end
`ifdef SEQ_GEN_GAP_EN
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = S_SEND;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are the registered image of the current state, giving one cycle from state to pins.
  always_comb begin
    x_d     = (state_q == S_SEND) && |(pat_q & (W'(1) << idx_q));
    valid_d = (state_q == S_SEND);
    busy_d  = (state_q != S_IDLE);
    done_d  = (state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
`ifdef SEQ_GEN_GAP_EN
      gap_q   <= '0;
`endif
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
`ifdef SEQ_GEN_GAP_EN
      gap_q   <= gap_d;
`endif
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_seq101_gen.sv
// Bench for seq101_gen: random and directed transfers compared cycle-by-cycle against a stream model.
module tb_seq101_gen;
  localparam int W   = 8;
  localparam int LW  = 4;
  localparam int RW  = 4;
  localparam int GAP = 2;
`ifdef SEQ_GEN_GAP_EN
  localparam int GAP_CYC = GAP;
`else
  localparam int GAP_CYC = 0;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  seq101_gen_if #(.W(W), .LW(LW), .RW(RW)) bus ();

  seq101_gen #(.W(W), .LW(LW), .RW(RW), .GAP(GAP)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  // Each entry is {x, valid, busy, done} for one cycle, sampled at the falling edge.
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];

  // Reference stream: one idle cycle, (r+1) copies of the pattern MSB-first with optional
  // zero gaps between them, then one done cycle and one idle cycle.
  task automatic model(input logic [7:0] p, input int l, input int r);
    exp_q.delete();
    exp_q.push_back(4'b0000);
    for (int k = 0; k <= r; k++) begin
      for (int i = l - 1; i >= 0; i--) exp_q.push_back({p[i], 1'b1, 1'b1, 1'b0});
      if (k < r) for (int g = 0; g < GAP_CYC; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endtask

  // Must be entered just after a falling edge. Starts a transfer, then keeps start high with
  // random data throughout (all of it must be ignored), recording outputs for exp_q.size() cycles.
  task automatic drive_xfer(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    int ncyc;
    ncyc = exp_q.size();
    obs_q.delete();
    bus.start = 1'b1; bus.pattern = p; bus.len = l; bus.rep = r;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      obs_q.push_back({bus.x, bus.valid, bus.busy, bus.done});
      if (c == ncyc - 2) begin
        bus.start = 1'b1; bus.pattern = 8'($urandom); bus.len = 4'd3; bus.rep = 4'd0;
      end else if (c == ncyc - 1) begin
        bus.start = 1'b0;
      end else begin
        bus.start = 1'b1; bus.pattern = 8'($urandom); bus.len = 4'($urandom); bus.rep = 4'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.start = 1'b1; bus.pattern = 8'h05; bus.len = 4'd3; bus.rep = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.x, bus.valid, bus.busy, bus.done} !== 4'b0000)
        $display("FAIL reset cyc%0d {x,valid,busy,done}=%b expected 0000", c, {bus.x, bus.valid, bus.busy, bus.done});
      else n_pass++;
    end
    bus.start = 1'b0;
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    model(8'b101, 3, 0);
    drive_xfer(8'b101, 4'd3, 4'd0);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_chk++;
      if (obs_q[c] !== exp_q[c])
        $display("FAIL basic cyc%0d {x,valid,busy,done}=%b expected %b", c, obs_q[c], exp_q[c]);
      else n_pass++;
    end
  endtask

  task automatic test_repeat();
    logic [2:0] sh;
    int nbits, hits;
    model(8'b101, 3, 2);
    drive_xfer(8'b101, 4'd3, 4'd2);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_chk++;
      if (obs_q[c] !== exp_q[c])
        $display("FAIL repeat cyc%0d {x,valid,busy,done}=%b expected %b", c, obs_q[c], exp_q[c]);
      else n_pass++;
    end
    // Overlapping 101 detector on the valid bits only.
    sh = '0; nbits = 0; hits = 0;
    foreach (obs_q[c]) begin
      if (obs_q[c][2]) begin
        sh = {sh[1:0], obs_q[c][3]};
        nbits++;
        if (nbits >= 3 && sh == 3'b101) hits++;
      end
    end
    n_chk++;
    if (hits !== 3) $display("FAIL repeat_detect matches=%0d expected 3", hits);
    else n_pass++;
  endtask

  task automatic test_invalid_len();
    logic [3:0] bad [4];
    bad[0] = 4'd0; bad[1] = 4'd9; bad[2] = 4'd15; bad[3] = 4'd0;
    @(negedge clk);
    bus.start = 1'b1; bus.pattern = 8'hA5; bus.len = bad[0]; bus.rep = 4'd1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.x, bus.valid, bus.busy, bus.done} !== 4'b0000)
        $display("FAIL invalid_len cyc%0d {x,valid,busy,done}=%b expected 0000", c, {bus.x, bus.valid, bus.busy, bus.done});
      else n_pass++;
      if (c < 4) bus.len = bad[c];
      else bus.start = 1'b0;
    end
  endtask

  task automatic test_clr_abort();
    int stray;
    @(negedge clk);
    bus.start = 1'b1; bus.pattern = 8'hFF; bus.len = 4'd8; bus.rep = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.x, bus.valid, bus.busy} !== 3'b111)
      $display("FAIL clr_presend {x,valid,busy}=%b expected 111", {bus.x, bus.valid, bus.busy});
    else n_pass++;
    #2 clr = 1'b1;
    #1;
    n_chk++;
    if ({bus.x, bus.valid, bus.busy, bus.done} !== 4'b0000)
      $display("FAIL clr_immediate {x,valid,busy,done}=%b expected 0000", {bus.x, bus.valid, bus.busy, bus.done});
    else n_pass++;
    @(negedge clk);
    clr = 1'b0;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      stray += int'(bus.done) + int'(bus.busy) + int'(bus.valid);
    end
    n_chk++;
    if (stray !== 0) $display("FAIL clr_no_done activity_cycles=%0d expected 0", stray);
    else n_pass++;
    model(8'b110, 3, 1);
    drive_xfer(8'b110, 4'd3, 4'd1);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_chk++;
      if (obs_q[c] !== exp_q[c])
        $display("FAIL clr_restart cyc%0d {x,valid,busy,done}=%b expected %b", c, obs_q[c], exp_q[c]);
      else n_pass++;
    end
  endtask

  task automatic test_long();
    int nvalid, ndone;
    @(negedge clk);
    model(8'b1100_0101, 8, 15);
    drive_xfer(8'b1100_0101, 4'd8, 4'd15);
    nvalid = 0; ndone = 0;
    for (int c = 0; c < exp_q.size(); c++) begin
      nvalid += int'(obs_q[c][2]);
      ndone  += int'(obs_q[c][0]);
      n_chk++;
      if (obs_q[c] !== exp_q[c])
        $display("FAIL long cyc%0d {x,valid,busy,done}=%b expected %b", c, obs_q[c], exp_q[c]);
      else n_pass++;
    end
    n_chk++;
    if (nvalid !== 128) $display("FAIL long_valid_bits got=%0d expected 128", nvalid);
    else n_pass++;
    n_chk++;
    if (ndone !== 1) $display("FAIL long_done_pulses got=%0d expected 1", ndone);
    else n_pass++;
  endtask

  // Second transfer is requested in the very cycle after the done pulse.
  task automatic test_back_to_back();
    logic [7:0] p;
    @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      p = 8'($urandom);
      model(p, 5, 1);
      drive_xfer(p, 4'd5, 4'd1);
      for (int c = 0; c < exp_q.size(); c++) begin
        n_chk++;
        if (obs_q[c] !== exp_q[c])
          $display("FAIL back_to_back t%0d cyc%0d {x,valid,busy,done}=%b expected %b", t, c, obs_q[c], exp_q[c]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] p;
    int l, r;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      p = 8'($urandom);
      l = int'($urandom_range(1, W));
      r = int'($urandom_range(0, 3));
      model(p, l, r);
      drive_xfer(p, 4'(l), 4'(r));
      for (int c = 0; c < exp_q.size(); c++) begin
        n_chk++;
        if (obs_q[c] !== exp_q[c])
          $display("FAIL random t%0d p=%h len=%0d rep=%0d cyc%0d {x,valid,busy,done}=%b expected %b",
                   t, p, l, r, c, obs_q[c], exp_q[c]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.pattern = '0; bus.len = '0; bus.rep = '0;
    test_reset();
    test_basic();
    test_repeat();
    test_invalid_len();
    test_clr_abort();
    test_long();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
